// File: rtl/ad_capture_pkg.sv
// Shared definitions for the ADC capture path: FSM encodings, default sizing and
// the per-frame configuration latched on start.
package ad_capture_pkg;

    localparam int unsigned DefDepth = 1024;
    localparam int unsigned DefAw    = 10;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StArm  = 3'd1;
    localparam logic [2:0] StTrig = 3'd2;
    localparam logic [2:0] StCapt = 3'd3;
    localparam logic [2:0] StRead = 3'd4;

    typedef struct packed {
        logic        mode;
        logic [7:0]  level;
        logic [15:0] decim;
    } cap_cfg_t;

    function automatic logic rising_cross(input logic [7:0] prev,
                                          input logic [7:0] cur,
                                          input logic [7:0] level);
        return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port frame buffer: synchronous write, registered 1-cycle read.
// No reset on the array or read register so it maps onto block RAM.
module sample_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ad_capture.sv
// ADC capture: drives clk_ad, decimates and triggers on the sampled bus, buffers one
// frame and streams it out on a valid/ready port.
module ad_capture
    import ad_capture_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        trig_mode,
    input  logic [7:0]  trig_level,
    input  logic [15:0] decim,
    input  logic [7:0]  ad_data,
    output logic        clk_ad,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    logic          clk_ad_q;
    logic [2:0]    state_q, state_d;
    cap_cfg_t      cfg_q;
    logic [15:0]   dcnt_q;
    logic          kept_q;
    logic [7:0]    s_cur_q, s_prev_q;
    logic [AW-1:0] waddr_q, raddr_q;
    logic          rd_pend_q, rd_valid_q, rd_last_q;
    logic          m_valid_q, m_last_q, done_q;
    logic [7:0]    m_data_q;

    logic          start_acc, trig_hit, ram_we, ram_re, out_free, move, last_hs, enter_read;
    logic [7:0]    ram_rdata;

    assign start_acc  = start && !abort && (state_q == StIdle);
    assign trig_hit   = rising_cross(s_prev_q, s_cur_q, cfg_q.level);
    assign last_hs    = (state_q == StRead) && m_valid_q && m_ready && m_last_q;
    assign enter_read = (state_q == StCapt) && (state_d == StRead);

    always_comb begin
        state_d = state_q;
        ram_we  = 1'b0;
        case (state_q)
            StIdle: if (start_acc) state_d = StArm;
            StArm:  if (kept_q) state_d = StTrig;
            StTrig: begin
                if (!cfg_q.mode) begin
                    state_d = StCapt;
                end else if (kept_q && trig_hit) begin
                    ram_we  = 1'b1;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                if (kept_q) begin
                    ram_we = 1'b1;
                    if (waddr_q == LastAddr) state_d = StRead;
                end
            end
            StRead: if (last_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Sampling runs in every state; kept_q marks the cycle after a kept sample lands
    // in s_cur, so the FSM sees a settled s_prev/s_cur pair.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_ad_q <= 1'b0;
            state_q  <= StIdle;
            cfg_q    <= '0;
            dcnt_q   <= '0;
            kept_q   <= 1'b0;
            s_cur_q  <= '0;
            s_prev_q <= '0;
            waddr_q  <= '0;
        end else begin
            clk_ad_q <= !clk_ad_q;
            state_q  <= state_d;
            if (start_acc) begin
                cfg_q   <= '{mode: trig_mode, level: trig_level, decim: decim};
                dcnt_q  <= '0;
                kept_q  <= 1'b0;
                waddr_q <= '0;
            end else begin
                kept_q <= 1'b0;
                if (clk_ad_q) begin
                    if (dcnt_q == cfg_q.decim) begin
                        dcnt_q   <= '0;
                        kept_q   <= 1'b1;
                        s_cur_q  <= ad_data;
                        s_prev_q <= s_cur_q;
                    end else begin
                        dcnt_q <= dcnt_q + 16'd1;
                    end
                end
                if (ram_we) waddr_q <= waddr_q + AW'(1);
            end
        end
    end

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (sys_clk),
        .we    (ram_we),
        .waddr (waddr_q),
        .wdata (s_cur_q),
        .re    (ram_re),
        .raddr (raddr_q),
        .rdata (ram_rdata)
    );

    // Two-stage read pipe: RAM output register, then the stream output register.
    // A new read is issued only when the RAM stage is empty or being drained.
    assign out_free = !m_valid_q || m_ready;
    assign move     = rd_valid_q && out_free;
    assign ram_re   = (state_q == StRead) && rd_pend_q && (!rd_valid_q || move);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            raddr_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            done_q     <= 1'b0;
        end else if (abort) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (enter_read) begin
                raddr_q   <= '0;
                rd_pend_q <= 1'b1;
            end else if (ram_re) begin
                raddr_q   <= raddr_q + AW'(1);
                rd_last_q <= (raddr_q == LastAddr);
                if (raddr_q == LastAddr) rd_pend_q <= 1'b0;
            end
            if (ram_re) begin
                rd_valid_q <= 1'b1;
            end else if (move) begin
                rd_valid_q <= 1'b0;
            end
            if (move) begin
                m_valid_q <= 1'b1;
                m_data_q  <= ram_rdata;
                m_last_q  <= rd_last_q;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    assign clk_ad  = clk_ad_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule

// File: tb/tb_ad_capture.sv
// Directed bench for ad_capture: ramp/triangle ADC model, frame collection with
// optional random backpressure, abort and asynchronous reset scenarios.
module tb_ad_capture;

    localparam int Depth = 1024;

    logic        sys_clk, sys_rst_n;
    logic        start, abort, trig_mode, m_ready;
    logic [7:0]  trig_level, ad_data, m_data;
    logic [15:0] decim;
    logic        clk_ad, m_valid, m_last, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] words [Depth];
    int n_w, last_pos, stab_err, bubbles, done_err, got_done, timed_out, first_valid;

    logic adc_tri, adc_up;

    ad_capture dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .ad_data    (ad_data),
        .clk_ad     (clk_ad),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = !sys_clk;
    end

    // ADC model: new sample on each clk_ad rising edge, ramp or triangle.
    always @(posedge clk_ad) begin
        if (!adc_tri) begin
            ad_data <= ad_data + 8'd1;
        end else if (adc_up) begin
            if (ad_data == 8'hFF) begin
                adc_up = 1'b0;
                ad_data <= 8'hFE;
            end else begin
                ad_data <= ad_data + 8'd1;
            end
        end else begin
            if (ad_data == 8'h00) begin
                adc_up = 1'b1;
                ad_data <= 8'h01;
            end else begin
                ad_data <= ad_data - 8'd1;
            end
        end
    end

    task automatic do_start(input logic mode, input logic [7:0] level, input logic [15:0] dec);
        @(negedge sys_clk);
        trig_mode  = mode;
        trig_level = level;
        decim      = dec;
        start      = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
    endtask

    // Gathers one frame into words[] and records protocol anomalies; no comparisons here.
    task automatic collect_frame(input int pct);
        logic       pv, pr, pl, seen, fin;
        logic [7:0] pd;
        int         cyc;
        n_w = 0; last_pos = -1; stab_err = 0; bubbles = 0; done_err = 0;
        got_done = 0; first_valid = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; seen = 1'b0; fin = 1'b0; cyc = 0;
        m_ready = 1'b0;
        while (!fin && cyc < 30000) begin
            @(negedge sys_clk);
            cyc++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stab_err++;
            if (done) done_err++;
            if (m_valid && !seen) begin
                seen = 1'b1;
                first_valid = cyc;
            end
            if (seen && !m_valid) bubbles++;
            m_ready = ($urandom_range(99) < pct);
            if (m_valid && m_ready) begin
                words[n_w] = m_data;
                if (m_last) begin
                    last_pos = n_w;
                    fin = 1'b1;
                end
                n_w++;
                if (n_w == Depth) fin = 1'b1;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
        timed_out = fin ? 0 : 1;
        @(negedge sys_clk);
        m_ready = 1'b0;
        got_done = done ? 1 : 0;
        @(negedge sys_clk);
        if (done) done_err++;
    endtask

    function automatic int step_errs(input logic [7:0] step);
        int e = 0;
        for (int k = 1; k < n_w; k++) begin
            if (words[k] !== words[k-1] + step) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b1;
        #3 sys_rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", m_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", m_data); end
        repeat (3) @(negedge sys_clk);
        checks++; if (clk_ad !== 1'b0) begin errors++; $display("FAIL reset_clk_ad: got %b expected 0", clk_ad); end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++; if (clk_ad !== 1'b1) begin errors++; $display("FAIL clk_ad_rise: got %b expected 1", clk_ad); end
        @(negedge sys_clk);
        checks++; if (clk_ad !== 1'b0) begin errors++; $display("FAIL clk_ad_fall: got %b expected 0", clk_ad); end
    endtask

    task automatic test_mode0();
        int e;
        adc_tri = 1'b0;
        do_start(1'b0, 8'h00, 16'd0);
        collect_frame(100);
        e = step_errs(8'd1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL m0_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_w != Depth) begin errors++; $display("FAIL m0_count: got %0d expected %0d", n_w, Depth); end
        checks++; if (last_pos != Depth - 1) begin errors++; $display("FAIL m0_last_pos: got %0d expected %0d", last_pos, Depth - 1); end
        checks++; if (e != 0) begin errors++; $display("FAIL m0_ramp: got %0d bad steps expected 0", e); end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL m0_back_to_back: got %0d bubbles expected 0", bubbles); end
        checks++; if (got_done != 1) begin errors++; $display("FAIL m0_done: got %0d expected 1", got_done); end
        checks++; if (done_err != 0) begin errors++; $display("FAIL m0_done_extra: got %0d expected 0", done_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_decim();
        int e;
        do_start(1'b0, 8'h00, 16'd3);
        collect_frame(100);
        e = step_errs(8'd4);
        checks++; if (n_w != Depth) begin errors++; $display("FAIL dec_count: got %0d expected %0d", n_w, Depth); end
        checks++; if (e != 0) begin errors++; $display("FAIL dec_step4: got %0d bad steps expected 0", e); end
        checks++;
        if (first_valid < 8192 || first_valid > 8240) begin
            errors++; $display("FAIL dec_capture_time: got %0d cycles expected 8192..8240", first_valid);
        end
    endtask

    task automatic test_trigger();
        int cyc;
        adc_tri = 1'b1;
        do_start(1'b1, 8'h80, 16'd0);
        collect_frame(100);
        checks++; if (n_w != Depth) begin errors++; $display("FAIL trig_count: got %0d expected %0d", n_w, Depth); end
        checks++; if (words[0] !== 8'h80) begin errors++; $display("FAIL trig_word0: got %h expected 80", words[0]); end
        checks++; if (words[1] !== 8'h81) begin errors++; $display("FAIL trig_word1: got %h expected 81", words[1]); end
        checks++; if (words[127] !== 8'hFF) begin errors++; $display("FAIL trig_word127: got %h expected ff", words[127]); end
        checks++; if (words[128] !== 8'hFE) begin errors++; $display("FAIL trig_word128: got %h expected fe", words[128]); end
        // Level 0 can never be crossed from below: the block must sit in TRIG.
        do_start(1'b1, 8'h00, 16'd0);
        repeat (600) @(negedge sys_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL trig_wait_busy: got %b expected 1", busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL trig_wait_valid: got %b expected 0", m_valid); end
        pulse_abort();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trig_abort_busy: got %b expected 0", busy); end
        cyc = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (done) cyc++;
        end
        checks++; if (cyc != 0) begin errors++; $display("FAIL trig_abort_done: got %0d pulses expected 0", cyc); end
        adc_tri = 1'b0;
    endtask

    task automatic test_backpressure();
        int e;
        do_start(1'b0, 8'h00, 16'd0);
        collect_frame(30);
        e = step_errs(8'd1);
        checks++; if (n_w != Depth) begin errors++; $display("FAIL bp_count: got %0d expected %0d", n_w, Depth); end
        checks++; if (last_pos != Depth - 1) begin errors++; $display("FAIL bp_last_pos: got %0d expected %0d", last_pos, Depth - 1); end
        checks++; if (e != 0) begin errors++; $display("FAIL bp_ramp: got %0d bad steps expected 0", e); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err); end
        checks++; if (got_done != 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", got_done); end
    endtask

    task automatic test_abort();
        int e, pulses;
        do_start(1'b0, 8'h00, 16'd0);
        repeat (300) @(negedge sys_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy_capt: got %b expected 1", busy); end
        pulse_abort();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy_clear: got %b expected 0", busy); end
        pulses = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (done || m_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL ab_no_done: got %0d expected 0", pulses); end
        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_start_same_cycle: got %b expected 0", busy); end
        do_start(1'b0, 8'h00, 16'd1);
        decim = 16'd5;
        collect_frame(100);
        e = step_errs(8'd2);
        checks++; if (n_w != Depth) begin errors++; $display("FAIL ab_new_count: got %0d expected %0d", n_w, Depth); end
        checks++; if (e != 0) begin errors++; $display("FAIL ab_new_step2: got %0d bad steps expected 0", e); end
    endtask

    task automatic test_reset_read();
        int cyc, e;
        do_start(1'b0, 8'h00, 16'd0);
        m_ready = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 5000) begin
            @(negedge sys_clk);
            cyc++;
        end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rr_reach_read: got %b expected 1", m_valid); end
        repeat (3) @(negedge sys_clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rr_stall_hold: got %b expected 1", m_valid); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || clk_ad !== 1'b0) begin
            errors++;
            $display("FAIL rr_async_clear: got valid=%b busy=%b last=%b data=%h clk_ad=%b expected all 0",
                     m_valid, busy, m_last, m_data, clk_ad);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        do_start(1'b0, 8'h00, 16'd0);
        collect_frame(100);
        e = step_errs(8'd1);
        checks++; if (n_w != Depth || last_pos != Depth - 1) begin errors++; $display("FAIL rr_frame: got %0d words last at %0d expected %0d", n_w, last_pos, Depth - 1); end
        checks++; if (e != 0) begin errors++; $display("FAIL rr_ramp: got %0d bad steps expected 0", e); end
        checks++; if (got_done != 1) begin errors++; $display("FAIL rr_done: got %0d expected 1", got_done); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_level = '0; decim = '0;
        m_ready = 1'b0; ad_data = '0; adc_tri = 1'b0; adc_up = 1'b1;
        test_reset();
        test_mode0();
        test_decim();
        test_trigger();
        test_backpressure();
        test_abort();
        test_reset_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
